bless_switch_traversal: RTL and testbench
=========================================

Name: bless_switch_traversal

Overview:
- Switch-traversal stage of the bufferless (BLESS) router; sits directly downstream of the sequential port-allocation chain.
- Inputs are up to NUM_PORT ranked flits (slot 0 = oldest), each with:
  - its one-hot allocated output port;
  - its productive-port vector (ppv).
- The block routes each flit through a crossbar and updates its age/hop field. It registers the result into per-output-port link registers, one-cycle latency.
- Also flags allocation faults and counts deflections.

Parameters:
- NUM_PORT, 5, number of router ports: N, E, S, W, local; bit i of every port vector = port i.
- FLIT_W, 64, flit width in bits including header.
- AGE_W, 8, width of the age/hop field, located at flit bits [AGE_W-1:0].
- DEF_CNT_W, 16, width of the deflection statistics counter.

Ports:
- clk  input  1  router clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flit_in  input  NUM_PORT*FLIT_W  ranked flits; slot i at bits [i*FLIT_W +: FLIT_W].
- valid_in  input  NUM_PORT  slot i carries a flit.
- alloc_in  input  NUM_PORT*NUM_PORT  allocatedPortVector per slot; slot i at [i*NUM_PORT +: NUM_PORT], one-hot.
- ppv_in  input  NUM_PORT*NUM_PORT  productive-port vector per slot, same packing.
- flit_out  output  NUM_PORT*FLIT_W  registered flit per output port p at [p*FLIT_W +: FLIT_W].
- valid_out  output  NUM_PORT  output port p carries a flit this cycle.
- deflect_out  output  NUM_PORT  the flit on port p was deflected (alloc & ppv == 0).
- alloc_err  output  1  sticky allocation-fault flag.
- stat_clr  input  1  clears deflection counter (effective only with feature enabled).
- deflect_cnt  output  DEF_CNT_W  cumulative deflection count.

Behaviour:
- Reset (reset=1 at clk edge), all of these are zero:
  - flit_out, valid_out, deflect_out;
  - alloc_err;
  - deflect_cnt.
- Reset takes priority over all other inputs in the same cycle.
- Latency: inputs sampled at edge k appear on the outputs after edge k. Throughput is one full set per cycle; there is no backpressure.
- Slot qualification:
  - Slot i is "live" iff valid_in[i]=1.
  - Non-live slots are ignored entirely, whatever their alloc or ppv values.
- Crossbar: output port p selects the lowest-index live slot i with alloc_in slot i bit p = 1.
  - valid_out[p]=1 iff such a slot exists; otherwise valid_out[p]=0.
  - When valid_out[p]=0, flit_out[p] is forced to 0.
- Age update: the selected flit is forwarded with bits [AGE_W-1:0] replaced by age+1, saturating at 2^AGE_W-1 (no wrap). All other bits pass unchanged.
- Deflection flag: deflect_out[p]=1 iff valid_out[p]=1 and (alloc_i & ppv_i)==0 for the selected slot i.
  - A ppv of all-zero counts as a deflection.
- Fault detection sets alloc_err=1 on the next edge in any of these cases:
  - a live slot whose alloc vector is zero; that flit is dropped;
  - a live slot whose alloc vector is not one-hot; the flit goes to the lowest-index set port only;
  - two or more live slots claim the same port; the lowest slot wins and the rest are dropped for that port.
- alloc_err is sticky and is cleared only by reset.
- Flits are never duplicated: a non-one-hot slot drives exactly one port.

Optional Feature:
- Macro: BLESS_DEFLECT_STATS_EN.
- Defined:
  - each cycle, deflect_cnt += popcount(deflect_out next-state), saturating at 2^DEF_CNT_W-1;
  - stat_clr=1 loads 0 and discards that cycle's increment;
  - reset also clears the counter.
- Not defined:
  - deflect_cnt is tied to 0 and stat_clr is ignored;
  - no counter flops are synthesised.
- deflect_out is present in both builds.

Test Plan:
- Reset while valid_in=11111 with legal allocations -> after edge, valid_out=0, flit_out=0, alloc_err=0, deflect_cnt=0; first normal cycle after reset deasserts behaves normally.
- Single flit: slot 0 live, age=0x05, alloc=00100, ppv=00100 -> next cycle valid_out=00100, port 2 age=0x06, deflect_out=0, deflect_cnt unchanged.
- Full load: 5 live slots; ages 0xFF, 3, 3, 3, 3; alloc = 00001, 00010, 00100, 01000, 10000; ppv hits only slots 0 and 1.
  - Required next cycle: valid_out=11111.
  - Port 0 age stays 0xFF (saturation).
  - deflect_out=11100.
  - With the feature enabled, deflect_cnt increases by 3.
- Conflict: slots 1 and 3 both alloc=01000 -> port 3 carries the slot-1 flit, slot-3 flit dropped, alloc_err=1 and remains 1 after ten idle cycles.
- Invalid slot with garbage: valid_in=00000, alloc all ones -> valid_out=0 and alloc_err stays 0. Separately, live slot with alloc=00000 -> no output, alloc_err=1.
- Stats (feature on):
  - drive 2 deflections/cycle for 4 cycles -> deflect_cnt=8;
  - assert stat_clr during a deflecting cycle -> 0;
  - force the counter to near max (DEF_CNT_W=4, preloaded 14) with 3 deflections -> 15.

Source files
------------

// File: rtl/bless_switch_traversal.sv
// BLESS router switch-traversal stage: crossbar, age/hop update, deflection flags and
// allocation-fault detection. Optional deflection counter behind BLESS_DEFLECT_STATS_EN.
module bless_switch_traversal #(
    parameter int NUM_PORT  = 5,
    parameter int FLIT_W    = 64,
    parameter int AGE_W     = 8,
    parameter int DEF_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORT*FLIT_W-1:0]    flit_in,
    input  logic [NUM_PORT-1:0]           valid_in,
    input  logic [NUM_PORT*NUM_PORT-1:0]  alloc_in,
    input  logic [NUM_PORT*NUM_PORT-1:0]  ppv_in,
    output logic [NUM_PORT*FLIT_W-1:0]    flit_out,
    output logic [NUM_PORT-1:0]           valid_out,
    output logic [NUM_PORT-1:0]           deflect_out,
    output logic                          alloc_err,
    input  logic                          stat_clr,
    output logic [DEF_CNT_W-1:0]          deflect_cnt
);

    logic [NUM_PORT*NUM_PORT-1:0] grant;
    logic [NUM_PORT-1:0]          grant_raw;
    logic [NUM_PORT*FLIT_W-1:0]   flit_nxt;
    logic [NUM_PORT-1:0]          valid_nxt;
    logic [NUM_PORT-1:0]          deflect_nxt;
    logic                         fault;
    logic [NUM_PORT-1:0]          claimed;
    logic [NUM_PORT-1:0]          fault_raw;

    function automatic logic [FLIT_W-1:0] age_inc(input logic [FLIT_W-1:0] f);
        logic [FLIT_W-1:0] r;
        r = f;
        if (!(&f[AGE_W-1:0])) begin
            r[AGE_W-1:0] = f[AGE_W-1:0] + 1'b1;
        end
        return r;
    endfunction

    // Each live slot keeps only its lowest set port, so a flit can never be duplicated.
    always_comb begin
        grant     = '0;
        grant_raw = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            grant_raw = alloc_in[i*NUM_PORT +: NUM_PORT];
            if (valid_in[i]) begin
                grant[i*NUM_PORT +: NUM_PORT] = grant_raw & (~grant_raw + 1'b1);
            end
        end
    end

    // Scan slots from highest to lowest so the oldest claimant overwrites and wins.
    always_comb begin
        flit_nxt    = '0;
        valid_nxt   = '0;
        deflect_nxt = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            for (int i = NUM_PORT - 1; i >= 0; i--) begin
                if (grant[i*NUM_PORT + p]) begin
                    valid_nxt[p]                 = 1'b1;
                    flit_nxt[p*FLIT_W +: FLIT_W] = age_inc(flit_in[i*FLIT_W +: FLIT_W]);
                    deflect_nxt[p] = ~|(alloc_in[i*NUM_PORT +: NUM_PORT] &
                                        ppv_in[i*NUM_PORT +: NUM_PORT]);
                end
            end
        end
    end

    always_comb begin
        fault     = 1'b0;
        claimed   = '0;
        fault_raw = '0;
        for (int i = 0; i < NUM_PORT; i++) begin
            fault_raw = alloc_in[i*NUM_PORT +: NUM_PORT];
            if (valid_in[i]) begin
                if (fault_raw == '0) begin
                    fault = 1'b1;
                end
                if ((fault_raw & (fault_raw - 1'b1)) != '0) begin
                    fault = 1'b1;
                end
                if ((claimed & fault_raw) != '0) begin
                    fault = 1'b1;
                end
                claimed = claimed | fault_raw;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flit_out    <= '0;
            valid_out   <= '0;
            deflect_out <= '0;
            alloc_err   <= 1'b0;
        end else begin
            flit_out    <= flit_nxt;
            valid_out   <= valid_nxt;
            deflect_out <= deflect_nxt;
            alloc_err   <= alloc_err | fault;
        end
    end

`ifdef BLESS_DEFLECT_STATS_EN
    localparam int POP_W = $clog2(NUM_PORT + 1);
    localparam int SUM_W = DEF_CNT_W + POP_W;

    logic [POP_W-1:0]     pop;
    logic [SUM_W-1:0]     cnt_sum;
    logic [DEF_CNT_W-1:0] cnt_q;
    logic [DEF_CNT_W-1:0] cnt_nxt;

    always_comb begin
        pop = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            pop = pop + POP_W'(deflect_nxt[p]);
        end
        cnt_sum = {{POP_W{1'b0}}, cnt_q} + SUM_W'(pop);
        cnt_nxt = cnt_q;
        if (cnt_sum > {{POP_W{1'b0}}, {DEF_CNT_W{1'b1}}}) begin
            cnt_nxt = {DEF_CNT_W{1'b1}};
        end else begin
            cnt_nxt = cnt_sum[DEF_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || stat_clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_nxt;
        end
    end

    assign deflect_cnt = cnt_q;
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign deflect_cnt     = '0;
`endif

endmodule

// File: tb/tb_bless_switch_traversal.sv
// Directed, table-driven bench for bless_switch_traversal plus hand sequences for
// reset, sticky fault and (when BLESS_DEFLECT_STATS_EN is defined) the counter.
module tb_bless_switch_traversal;
    localparam int NP  = 5;
    localparam int FW  = 64;
    localparam int AW  = 8;
    localparam int DCW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP*FW-1:0]  flit_in;
    logic [NP-1:0]     valid_in;
    logic [NP*NP-1:0]  alloc_in;
    logic [NP*NP-1:0]  ppv_in;
    logic [NP*FW-1:0]  flit_out;
    logic [NP-1:0]     valid_out;
    logic [NP-1:0]     deflect_out;
    logic              alloc_err;
    logic              stat_clr;
    logic [DCW-1:0]    deflect_cnt;

    int total = 0;
    int bad   = 0;
    int cnt_model = 0;

    bless_switch_traversal #(.NUM_PORT(NP), .FLIT_W(FW), .AGE_W(AW), .DEF_CNT_W(DCW)) dut (
        .clk(clk), .reset(reset), .flit_in(flit_in), .valid_in(valid_in),
        .alloc_in(alloc_in), .ppv_in(ppv_in), .flit_out(flit_out), .valid_out(valid_out),
        .deflect_out(deflect_out), .alloc_err(alloc_err), .stat_clr(stat_clr),
        .deflect_cnt(deflect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic         rst;
        logic [4:0]   valid;
        logic [24:0]  alloc;
        logic [24:0]  ppv;
        logic [39:0]  ages;
        logic [4:0]   ev;
        logic [4:0]   ed;
        logic [14:0]  esrc;
        logic [39:0]  eage;
        logic         eerr;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [FW-1:0] mk_flit(input int src, input logic [AW-1:0] age);
        logic [3:0] s;
        s = 4'(src);
        return {4'hA, s, 48'h0123_4567_89AB, age};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_in = '0;
        alloc_in = '0;
        ppv_in   = '0;
        flit_in  = '0;
        stat_clr = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cnt_model = 0;
    endtask

    task automatic drive(input logic [4:0] v, input logic [24:0] a, input logic [24:0] pv,
                         input logic [39:0] ages);
        valid_in = v;
        alloc_in = a;
        ppv_in   = pv;
        for (int i = 0; i < NP; i++) flit_in[i*FW +: FW] = mk_flit(i, ages[i*8 +: 8]);
    endtask

    function automatic int popc(input logic [4:0] d);
        int n = 0;
        for (int i = 0; i < 5; i++) n += int'(d[i]);
        return n;
    endfunction

    function automatic int cnt_step(input int c, input int inc, input logic clr);
`ifdef BLESS_DEFLECT_STATS_EN
        if (clr) return 0;
        return (c + inc > (1 << DCW) - 1) ? (1 << DCW) - 1 : c + inc;
`else
        return 0 * (c + inc + int'(clr));
`endif
    endfunction

    initial begin
        //      rst   valid     alloc {s4..s0}                                   ppv {s4..s0}                                     ages {s4..s0}                          ev        ed        esrc {p4..p0}                   eage {p4..p0}                           err
        tbl[0] = '{1'b0, 5'b00001, {5'b0,5'b0,5'b0,5'b0,5'b00100},                {5'b0,5'b0,5'b0,5'b0,5'b00100},                {8'h0,8'h0,8'h0,8'h0,8'h05},      5'b00100, 5'b00000, {3'd7,3'd7,3'd0,3'd7,3'd7}, {8'h0,8'h0,8'h06,8'h0,8'h0},      1'b0};
        tbl[1] = '{1'b0, 5'b11111, {5'b10000,5'b01000,5'b00100,5'b00010,5'b00001}, {5'b0,5'b0,5'b0,5'b00010,5'b00001},          {8'h3,8'h3,8'h3,8'h3,8'hFF},      5'b11111, 5'b11100, {3'd4,3'd3,3'd2,3'd1,3'd0}, {8'h4,8'h4,8'h4,8'h4,8'hFF},      1'b0};
        tbl[2] = '{1'b0, 5'b00100, {5'b0,5'b0,5'b00001,5'b0,5'b0},                {5'b0,5'b0,5'b00010,5'b0,5'b0},                {8'h0,8'h0,8'h07,8'h0,8'h0},      5'b00001, 5'b00001, {3'd7,3'd7,3'd7,3'd7,3'd2}, {8'h0,8'h0,8'h0,8'h0,8'h08},      1'b0};
        tbl[3] = '{1'b0, 5'b00000, 25'h1FF_FFFF,                                  25'h1FF_FFFF,                                  40'h0,                            5'b00000, 5'b00000, {3'd7,3'd7,3'd7,3'd7,3'd7}, 40'h0,                            1'b0};
        tbl[4] = '{1'b0, 5'b01010, {5'b0,5'b00010,5'b0,5'b10000,5'b11111},        {5'b0,5'b00000,5'b0,5'b10000,5'b11111},        {8'h0,8'hFE,8'h0,8'h10,8'h33},    5'b10010, 5'b00010, {3'd1,3'd7,3'd7,3'd3,3'd7}, {8'h11,8'h0,8'h0,8'hFF,8'h0},     1'b0};
        tbl[5] = '{1'b1, 5'b01010, {5'b0,5'b01000,5'b0,5'b01000,5'b0},            {5'b0,5'b0,5'b0,5'b01000,5'b0},                {8'h0,8'h02,8'h0,8'h01,8'h0},     5'b01000, 5'b00000, {3'd7,3'd1,3'd7,3'd7,3'd7}, {8'h0,8'h02,8'h0,8'h0,8'h0},      1'b1};
        tbl[6] = '{1'b1, 5'b00001, 25'h0,                                         {5'b0,5'b0,5'b0,5'b0,5'b11111},                {8'h0,8'h0,8'h0,8'h0,8'h09},      5'b00000, 5'b00000, {3'd7,3'd7,3'd7,3'd7,3'd7}, 40'h0,                            1'b1};
        tbl[7] = '{1'b1, 5'b00001, {5'b0,5'b0,5'b0,5'b0,5'b10100},                {5'b0,5'b0,5'b0,5'b0,5'b00100},                {8'h0,8'h0,8'h0,8'h0,8'h00},      5'b00100, 5'b00000, {3'd7,3'd7,3'd0,3'd7,3'd7}, {8'h0,8'h0,8'h01,8'h0,8'h0},      1'b1};
        tbl[8] = '{1'b0, 5'b00010, {5'b0,5'b0,5'b0,5'b00001,5'b0},                {5'b0,5'b0,5'b0,5'b00001,5'b0},                {8'h0,8'h0,8'h0,8'hFF,8'h0},      5'b00001, 5'b00000, {3'd7,3'd7,3'd7,3'd7,3'd1}, {8'h0,8'h0,8'h0,8'h0,8'hFF},      1'b1};
        tbl[9] = '{1'b1, 5'b10000, {5'b01000,5'b0,5'b0,5'b0,5'b0},                {5'b00001,5'b0,5'b0,5'b0,5'b0},                {8'h20,8'h0,8'h0,8'h0,8'h0},      5'b01000, 5'b01000, {3'd7,3'd4,3'd7,3'd7,3'd7}, {8'h0,8'h21,8'h0,8'h0,8'h0},      1'b0};

        // Reset while a full legal load is presented.
        idle_inputs();
        reset = 1'b1;
        drive(5'b11111, {5'b10000,5'b01000,5'b00100,5'b00010,5'b00001}, 25'h1FF_FFFF, 40'h0101010101);
        tick();
        check("rst_valid", 64'(valid_out), 64'h0);
        check("rst_flit_lo", flit_out[63:0], 64'h0);
        check("rst_flit_any", 64'(|flit_out), 64'h0);
        check("rst_defl", 64'(deflect_out), 64'h0);
        check("rst_err", 64'(alloc_err), 64'h0);
        check("rst_cnt", 64'(deflect_cnt), 64'h0);
        reset = 1'b0;
        cnt_model = 0;

        for (int k = 0; k < 10; k++) begin
            if (tbl[k].rst) begin
                idle_inputs();
                do_reset();
            end
            drive(tbl[k].valid, tbl[k].alloc, tbl[k].ppv, tbl[k].ages);
            tick();
            cnt_model = cnt_step(cnt_model, popc(tbl[k].ed), 1'b0);
            check($sformatf("v%0d_valid", k), 64'(valid_out), 64'(tbl[k].ev));
            check($sformatf("v%0d_defl", k), 64'(deflect_out), 64'(tbl[k].ed));
            check($sformatf("v%0d_err", k), 64'(alloc_err), 64'(tbl[k].eerr));
            check($sformatf("v%0d_cnt", k), 64'(deflect_cnt), 64'(cnt_model));
            for (int p = 0; p < NP; p++) begin
                check($sformatf("v%0d_flit_p%0d", k, p), flit_out[p*FW +: FW],
                      tbl[k].ev[p] ? mk_flit(int'(tbl[k].esrc[p*3 +: 3]), tbl[k].eage[p*8 +: 8]) : 64'h0);
            end
        end

        // Conflict fault stays latched through idle cycles.
        idle_inputs();
        do_reset();
        drive(tbl[5].valid, tbl[5].alloc, tbl[5].ppv, tbl[5].ages);
        tick();
        check("conf_p3", flit_out[3*FW +: FW], mk_flit(1, 8'h02));
        idle_inputs();
        for (int c = 0; c < 10; c++) tick();
        check("conf_sticky_err", 64'(alloc_err), 64'h1);
        check("conf_idle_valid", 64'(valid_out), 64'h0);

        // Two deflections per cycle, then clear, then saturate.
        idle_inputs();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive(5'b00011, {5'b0,5'b0,5'b0,5'b00010,5'b00001}, 25'h0, 40'h0);
            tick();
        end
        check("stat_defl2", 64'(deflect_out), 64'h3);
`ifdef BLESS_DEFLECT_STATS_EN
        check("stat_cnt8", 64'(deflect_cnt), 64'd8);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_clr", 64'(deflect_cnt), 64'd0);
        for (int c = 0; c < 7; c++) tick();
        check("stat_cnt14", 64'(deflect_cnt), 64'd14);
        drive(5'b00111, {5'b0,5'b0,5'b00100,5'b00010,5'b00001}, 25'h0, 40'h0);
        tick();
        check("stat_sat", 64'(deflect_cnt), 64'd15);
        tick();
        check("stat_sat_hold", 64'(deflect_cnt), 64'd15);
`else
        check("stat_off_cnt", 64'(deflect_cnt), 64'd0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat_off_clr_cnt", 64'(deflect_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
